mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter DMA_STARVE, default 7: number of consecutive lost DMA arbitrations after which DMA outranks CPU (range 1..15).
REQ-002 fclk  in  1  system clock; the only clock in the block.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 cend, pre_cend  out  1 each  DRAM cycle-end and pre-cycle-end strobes, one fclk wide.
REQ-005 cpu_req, cpu_rnw, cpu_wrbsel  in  1 each  CPU request (level), read-not-write, byte select.
REQ-006 cpu_addr  in  21; cpu_wrdata  in  8  CPU word address and write byte.
REQ-007 cpu_strobe  out  1  CPU read data valid on rddata.
REQ-008 vid_req  in  1; vid_addr  in  21; vid_strobe  out  1  video read port, read-only.
REQ-009 dma_req, dma_rnw, dma_wrbsel  in  1 each; dma_addr  in  21; dma_wrdata  in  8; dma_ack  out  1; dma_strobe  out  1  DMA port.
REQ-010 dram_req  out  1; dram_rnw  out  1; dram_addr  out  21; dram_wrdata  out  8; dram_bsel  out  1  DRAM controller command.
REQ-011 dram_rddata  in  16; rddata  out  16  DRAM read word, forwarded unregistered to all requesters.

Function
REQ-012 2-bit phase counter shall run 0,1,2,3,0... continuously; pre_cend=1 exactly when phase==2, cend=1 exactly when phase==3.
REQ-013 Arbitration shall happen only on the fclk where cend=1; the winner owns the following 4-phase cycle.
REQ-014 Owner encoding: NONE, VID, CPU, DMA; owner register updates only at cend.
REQ-015 Priority: VID > CPU > DMA, except DMA > CPU when the starvation counter equals DMA_STARVE.
REQ-016 CPU pending latch: set on any fclk with cpu_req=1; cleared at the cend that grants CPU; on the same fclk, clear wins over set.
REQ-017 The CPU competes when the pending latch is set or cpu_req=1 at the arbitration cend; VID and DMA compete only when their req is 1 at that cend.
REQ-018 Starvation counter, 4 bits: +1 at each cend where DMA competes and loses; 0 when DMA wins or does not compete; saturates at DMA_STARVE.
REQ-019 At grant cend, dram_addr, dram_rnw, dram_bsel and dram_wrdata shall be registered from the winner and held for the whole owned cycle.
REQ-020 VID grants shall force dram_rnw=1 and dram_bsel=0.
REQ-021 dram_req shall be 1 for exactly one fclk, at phase 0 of each non-NONE cycle; it shall be 0 in NONE cycles.
REQ-022 dma_ack shall pulse for one fclk at phase 0 of each DMA-owned cycle; DMA may change its request fields after dma_ack.
REQ-023 cpu_strobe, vid_strobe, dma_strobe shall pulse at phase 3 (coincident with cend) of an owned read cycle of that owner only; never for writes.
REQ-024 rddata shall equal dram_rddata combinationally; it is valid only while a strobe is high.
REQ-025 Grant-to-strobe latency shall be 4 fclk (grant cend -> next cend); back-to-back cycles to one owner are allowed.
REQ-026 A request dropped before its cend shall not be granted (CPU excepted, via REQ-016).

Reset
REQ-027 While rst=1: phase=0, owner=NONE, CPU pending=0, starvation counter=0, all dram_* registers=0.
REQ-028 While rst=1, all strobes, dram_req and dma_ack shall be 0; any in-flight cycle is abandoned with no strobe.
REQ-029 The first cend shall occur 4 fclk after rst deasserts.

Configuration
REQ-030 Macro MEM_ARBITER_DMA_EN defined: DMA port operates per REQ-009..REQ-026.
REQ-031 Macro MEM_ARBITER_DMA_EN undefined: DMA never competes; the starvation counter is absent; dma_ack=0 and dma_strobe=0 permanently; DMA inputs are ignored.

Verification
REQ-032 CPU read only, cpu_addr=0x12345, cpu_req high at a cend, dram_rddata=0xA55A -> dram_req at next phase 0, dram_addr=0x12345, cpu_strobe at next cend, rddata=0xA55A.
REQ-033 vid_req, cpu_req and dma_req all high at the same cend -> VID owns; CPU owns the next cycle; DMA owns the one after.
REQ-034 cpu_req 1-fclk pulse at phase 1, low at cend -> CPU granted at that cend; a pulse coincident with its grant cend is not re-granted.
REQ-035 DMA_STARVE=3, cpu_req and dma_req held continuously -> CPU wins 3 cycles, then DMA wins 1 (dma_ack pulse), then the pattern repeats.
REQ-036 rst asserted at phase 2 of a CPU read -> no cpu_strobe; after release, the first cend occurs 4 fclk later with owner NONE.

Source files
------------

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - four-phase DRAM arbiter for video, CPU and DMA requesters
// Define MEM_ARBITER_DMA_EN to enable the DMA port and its starvation counter.
module mem_arbiter #(
    parameter int DMA_STARVE = 7
) (
    input  logic        fclk,
    input  logic        rst,

    output logic        cend,
    output logic        pre_cend,

    input  logic        cpu_req,
    input  logic        cpu_rnw,
    input  logic        cpu_wrbsel,
    input  logic [20:0] cpu_addr,
    input  logic [7:0]  cpu_wrdata,
    output logic        cpu_strobe,

    input  logic        vid_req,
    input  logic [20:0] vid_addr,
    output logic        vid_strobe,

    input  logic        dma_req,
    input  logic        dma_rnw,
    input  logic        dma_wrbsel,
    input  logic [20:0] dma_addr,
    input  logic [7:0]  dma_wrdata,
    output logic        dma_ack,
    output logic        dma_strobe,

    output logic        dram_req,
    output logic        dram_rnw,
    output logic [20:0] dram_addr,
    output logic [7:0]  dram_wrdata,
    output logic        dram_bsel,

    input  logic [15:0] dram_rddata,
    output logic [15:0] rddata
);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_VID  = 2'd1,
        OWN_CPU  = 2'd2,
        OWN_DMA  = 2'd3
    } owner_t;

    logic [1:0] phase;
    owner_t     owner_q;
    owner_t     owner_d;
    owner_t     winner;
    logic       cpu_pend;
    logic       cpu_comp;
    logic       dma_comp;
    logic       dma_first;

    always_ff @(posedge fclk) begin
        if (rst) begin
            phase <= 2'd0;
        end else begin
            phase <= phase + 2'd1;
        end
    end

    assign pre_cend = (phase == 2'd2);
    assign cend     = (phase == 2'd3);

    assign cpu_comp = cpu_pend | cpu_req;

`ifdef MEM_ARBITER_DMA_EN
    logic [3:0] starve_cnt;

    assign dma_comp  = dma_req;
    assign dma_first = (starve_cnt == 4'(DMA_STARVE));

    // Counts consecutive lost arbitrations; holds once DMA has earned priority.
    always_ff @(posedge fclk) begin
        if (rst) begin
            starve_cnt <= 4'd0;
        end else if (cend) begin
            if (dma_comp && (winner != OWN_DMA)) begin
                if (!dma_first) begin
                    starve_cnt <= starve_cnt + 4'd1;
                end
            end else begin
                starve_cnt <= 4'd0;
            end
        end
    end
`else
    logic unused_dma;

    assign dma_comp   = 1'b0;
    assign dma_first  = 1'b0;
    assign unused_dma = ^{dma_req, dma_rnw, dma_wrbsel, dma_addr, dma_wrdata, 4'(DMA_STARVE)};
`endif

    always_ff @(posedge fclk) begin
        if (rst) begin
            owner_q <= OWN_NONE;
        end else begin
            owner_q <= owner_d;
        end
    end

    always_comb begin
        winner  = OWN_NONE;
        owner_d = owner_q;
        if (vid_req) begin
            winner = OWN_VID;
        end else if (dma_comp && dma_first) begin
            winner = OWN_DMA;
        end else if (cpu_comp) begin
            winner = OWN_CPU;
        end else if (dma_comp) begin
            winner = OWN_DMA;
        end
        if (cend) begin
            owner_d = winner;
        end
    end

    // A grant to the CPU clears the latch even if cpu_req is still high on that edge.
    always_ff @(posedge fclk) begin
        if (rst) begin
            cpu_pend <= 1'b0;
        end else if (cend && (winner == OWN_CPU)) begin
            cpu_pend <= 1'b0;
        end else if (cpu_req) begin
            cpu_pend <= 1'b1;
        end
    end

    always_ff @(posedge fclk) begin
        if (rst) begin
            dram_addr   <= 21'd0;
            dram_rnw    <= 1'b0;
            dram_bsel   <= 1'b0;
            dram_wrdata <= 8'd0;
        end else if (cend) begin
            case (winner)
                OWN_VID: begin
                    dram_addr   <= vid_addr;
                    dram_rnw    <= 1'b1;
                    dram_bsel   <= 1'b0;
                    dram_wrdata <= 8'd0;
                end
                OWN_CPU: begin
                    dram_addr   <= cpu_addr;
                    dram_rnw    <= cpu_rnw;
                    dram_bsel   <= cpu_wrbsel;
                    dram_wrdata <= cpu_wrdata;
                end
`ifdef MEM_ARBITER_DMA_EN
                OWN_DMA: begin
                    dram_addr   <= dma_addr;
                    dram_rnw    <= dma_rnw;
                    dram_bsel   <= dma_wrbsel;
                    dram_wrdata <= dma_wrdata;
                end
`endif
                default: begin
                end
            endcase
        end
    end

    assign dram_req   = !rst && (owner_q != OWN_NONE) && (phase == 2'd0);
    assign cpu_strobe = !rst && cend && (owner_q == OWN_CPU) && dram_rnw;
    assign vid_strobe = !rst && cend && (owner_q == OWN_VID);

`ifdef MEM_ARBITER_DMA_EN
    assign dma_ack    = !rst && (owner_q == OWN_DMA) && (phase == 2'd0);
    assign dma_strobe = !rst && cend && (owner_q == OWN_DMA) && dram_rnw;
`else
    assign dma_ack    = 1'b0;
    assign dma_strobe = 1'b0;
`endif

    assign rddata = dram_rddata;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed and randomized checks of mem_arbiter against a cycle-level model
module tb_mem_arbiter;

    localparam int STARVE = 3;
`ifdef MEM_ARBITER_DMA_EN
    localparam bit DMA_ON = 1'b1;
`else
    localparam bit DMA_ON = 1'b0;
`endif
    localparam int O_NONE = 0;
    localparam int O_VID  = 1;
    localparam int O_CPU  = 2;
    localparam int O_DMA  = 3;

    logic fclk = 1'b0;
    always #5 fclk = ~fclk;

    logic        rst = 1'b1;
    logic        cpu_req = 1'b0, cpu_rnw = 1'b0, cpu_wrbsel = 1'b0;
    logic [20:0] cpu_addr = '0;
    logic [7:0]  cpu_wrdata = '0;
    logic        vid_req = 1'b0;
    logic [20:0] vid_addr = '0;
    logic        dma_req = 1'b0, dma_rnw = 1'b0, dma_wrbsel = 1'b0;
    logic [20:0] dma_addr = '0;
    logic [7:0]  dma_wrdata = '0;
    logic [15:0] dram_rddata = '0;

    logic        cend, pre_cend, cpu_strobe, vid_strobe, dma_ack, dma_strobe;
    logic        dram_req, dram_rnw, dram_bsel;
    logic [20:0] dram_addr;
    logic [7:0]  dram_wrdata;
    logic [15:0] rddata;

    mem_arbiter #(.DMA_STARVE(STARVE)) dut (
        .fclk(fclk), .rst(rst), .cend(cend), .pre_cend(pre_cend),
        .cpu_req(cpu_req), .cpu_rnw(cpu_rnw), .cpu_wrbsel(cpu_wrbsel),
        .cpu_addr(cpu_addr), .cpu_wrdata(cpu_wrdata), .cpu_strobe(cpu_strobe),
        .vid_req(vid_req), .vid_addr(vid_addr), .vid_strobe(vid_strobe),
        .dma_req(dma_req), .dma_rnw(dma_rnw), .dma_wrbsel(dma_wrbsel),
        .dma_addr(dma_addr), .dma_wrdata(dma_wrdata), .dma_ack(dma_ack),
        .dma_strobe(dma_strobe), .dram_req(dram_req), .dram_rnw(dram_rnw),
        .dram_addr(dram_addr), .dram_wrdata(dram_wrdata), .dram_bsel(dram_bsel),
        .dram_rddata(dram_rddata), .rddata(rddata)
    );

    int pass_cnt = 0;
    int fail_cnt = 0;
    int total_cnt = 0;

    // Model: fclk count since reset, pending CPU flag, lost-arbitration count, owner and latched command.
    int          m_t = 0;
    bit          m_pend = 1'b0;
    int          m_starve = 0;
    int          m_own = O_NONE;
    logic [20:0] m_addr = '0;
    bit          m_rnw = 1'b0, m_bsel = 1'b0;
    logic [7:0]  m_wd = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        int ph = m_t % 4;
        bit live = !rst;
        check("cend", cend, ph == 3);
        check("pre_cend", pre_cend, ph == 2);
        check("dram_req", dram_req, live && m_own != O_NONE && ph == 0);
        check("dma_ack", dma_ack, live && m_own == O_DMA && ph == 0);
        check("cpu_strobe", cpu_strobe, live && ph == 3 && m_own == O_CPU && m_rnw);
        check("vid_strobe", vid_strobe, live && ph == 3 && m_own == O_VID);
        check("dma_strobe", dma_strobe, live && ph == 3 && m_own == O_DMA && m_rnw);
        check("dram_addr", dram_addr, m_addr);
        check("dram_rnw", dram_rnw, m_rnw);
        check("dram_bsel", dram_bsel, m_bsel);
        check("dram_wrdata", dram_wrdata, m_wd);
        check("rddata", rddata, dram_rddata);
    endtask

    task automatic model_step();
        if (rst) begin
            m_t = 0; m_pend = 0; m_starve = 0; m_own = O_NONE;
            m_addr = '0; m_rnw = 0; m_bsel = 0; m_wd = '0;
        end else begin
            if (m_t % 4 == 3) begin
                bit v = vid_req;
                bit c = m_pend || cpu_req;
                bit d = DMA_ON && dma_req;
                int w;
                if (v) w = O_VID;
                else if (d && m_starve == STARVE) w = O_DMA;
                else if (c) w = O_CPU;
                else if (d) w = O_DMA;
                else w = O_NONE;
                if (d && w != O_DMA) m_starve = (m_starve + 1 > STARVE) ? STARVE : m_starve + 1;
                else m_starve = 0;
                if (w == O_CPU) m_pend = 0;
                else if (cpu_req) m_pend = 1;
                m_own = w;
                if (w == O_VID) begin
                    m_addr = vid_addr; m_rnw = 1; m_bsel = 0; m_wd = '0;
                end else if (w == O_CPU) begin
                    m_addr = cpu_addr; m_rnw = cpu_rnw; m_bsel = cpu_wrbsel; m_wd = cpu_wrdata;
                end else if (w == O_DMA) begin
                    m_addr = dma_addr; m_rnw = dma_rnw; m_bsel = dma_wrbsel; m_wd = dma_wrdata;
                end
            end else if (cpu_req) begin
                m_pend = 1;
            end
            m_t++;
        end
    endtask

    task automatic tick();
        #1;
        check_outputs();
        @(posedge fclk);
        model_step();
        @(negedge fclk);
    endtask

    task automatic go_phase(input int p);
        for (int i = 0; i < 4 && (m_t % 4) != p; i++) tick();
    endtask

    task automatic idle_inputs();
        cpu_req = 0; vid_req = 0; dma_req = 0;
    endtask

    initial begin
        int  n;
        bit  found, strobe_seen, req_seen;

        @(posedge fclk);
        model_step();
        @(negedge fclk);
        for (int i = 0; i < 3; i++) tick();
        rst = 0;

        // CPU read of 0x12345 returning 0xA55A
        go_phase(3);
        cpu_req = 1; cpu_rnw = 1; cpu_addr = 21'h12345;
        tick();
        cpu_req = 0;
        #1;
        check("r32_dram_req", dram_req, 1);
        check("r32_dram_addr", dram_addr, 21'h12345);
        tick(); tick(); tick();
        dram_rddata = 16'hA55A;
        #1;
        check("r32_cpu_strobe", cpu_strobe, 1);
        check("r32_rddata", rddata, 16'hA55A);
        tick();

        // all three request at once: VID, then CPU, then DMA
        go_phase(3);
        vid_req = 1; vid_addr = 21'h0AAAA;
        cpu_req = 1; cpu_rnw = 1; cpu_addr = 21'h11111;
        dma_req = 1; dma_rnw = 1; dma_addr = 21'h1DDDD;
        tick();
        vid_req = 0; cpu_req = 0;
        #1;
        check("r33_first_addr", dram_addr, 21'h0AAAA);
        for (int i = 0; i < 4; i++) tick();
        #1;
        check("r33_second_addr", dram_addr, 21'h11111);
        check("r33_second_ack", dma_ack, 0);
        for (int i = 0; i < 4; i++) tick();
        #1;
        check("r33_third_req_ack", {dram_req, dma_ack}, DMA_ON ? 2'b11 : 2'b00);
        check("r33_third_addr", dram_addr, DMA_ON ? 21'h1DDDD : 21'h11111);
        dma_req = 0;

        // single-fclk CPU pulse at phase 1 is latched; a pulse on its grant cend is not
        go_phase(1);
        cpu_req = 1; cpu_rnw = 0; cpu_addr = 21'h02468; cpu_wrdata = 8'h5C; cpu_wrbsel = 1;
        tick();
        cpu_req = 0;
        go_phase(0);
        #1;
        check("r34_req", dram_req, 1);
        check("r34_addr", dram_addr, 21'h02468);
        check("r34_wrdata", dram_wrdata, 8'h5C);
        check("r34_rnw", dram_rnw, 0);
        go_phase(1);
        cpu_req = 1;
        tick();
        cpu_req = 0;
        go_phase(3);
        #1;
        check("r34_write_no_strobe", cpu_strobe, 0);
        cpu_req = 1;
        tick();
        cpu_req = 0;
        #1;
        check("r34_regrant", dram_req, 1);
        for (int i = 0; i < 4; i++) tick();
        #1;
        check("r34_no_second_grant", dram_req, 0);

        // CPU and DMA held: DMA wins after STARVE lost arbitrations
        go_phase(3);
        cpu_req = 1; cpu_rnw = 1; cpu_addr = 21'h00C0C;
        dma_req = 1; dma_rnw = 1; dma_addr = 21'h00D0D;
        tick();
        for (int k = 0; k < 8; k++) begin
            #1;
            check("r35_ack", dma_ack, DMA_ON && (k % 4 == 3));
            check("r35_req", dram_req, 1);
            for (int i = 0; i < 4; i++) tick();
        end
        idle_inputs();

        // reset at phase 2 of a CPU read abandons it
        go_phase(3);
        cpu_req = 1; cpu_rnw = 1; cpu_addr = 21'h1F00F;
        tick();
        cpu_req = 0;
        go_phase(2);
        strobe_seen = 0; req_seen = 0;
        rst = 1;
        for (int i = 0; i < 2; i++) begin
            #1;
            if (cpu_strobe) strobe_seen = 1;
            tick();
        end
        rst = 0;
        n = 0; found = 0;
        for (int i = 0; i < 8; i++) begin
            #1;
            if (!found) begin
                n++;
                if (cend) found = 1;
            end
            if (cpu_strobe) strobe_seen = 1;
            if (dram_req) req_seen = 1;
            tick();
        end
        check("r36_first_cend", n, 4);
        check("r36_no_strobe", strobe_seen, 0);
        check("r36_owner_none", req_seen, 0);

        // randomized traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            rst         = ($urandom_range(0, 199) == 0);
            vid_req     = ($urandom_range(0, 3) == 0);
            vid_addr    = 21'($urandom);
            cpu_req     = ($urandom_range(0, 2) == 0);
            cpu_rnw     = 1'($urandom);
            cpu_wrbsel  = 1'($urandom);
            cpu_addr    = 21'($urandom);
            cpu_wrdata  = 8'($urandom);
            dma_req     = ($urandom_range(0, 1) == 0);
            dma_rnw     = 1'($urandom);
            dma_wrbsel  = 1'($urandom);
            dma_addr    = 21'($urandom);
            dma_wrdata  = 8'($urandom);
            dram_rddata = 16'($urandom);
            tick();
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
